// File: rtl/pipe_stage.sv
// Two-entry skid pipeline register between a valid/ready producer and consumer.
// Latency: 1 cycle from push into an empty stage to out_valid/out_data.
// Backpressure: in_ready is decoded from registered occupancy only; the skid entry absorbs one beat.
module pipe_stage #(
    parameter int                DATA_W     = 96,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
    parameter int                CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]        occ;
    logic [DATA_W-1:0] main_dat;
    logic [DATA_W-1:0] skid_dat;
    logic              push;
    logic              pop;

    assign in_ready  = (occ != 2'd2);
    assign out_valid = (occ != 2'd0);
    assign out_data  = out_valid ? main_dat : BUBBLE_VAL;
    assign occupancy = occ;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Control state: reset wins over flush, flush wins over push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ       <= 2'd0;
            stall_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && !flush && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush) begin
                occ <= 2'd0;
            end else begin
                case (occ)
                    2'd0: if (push) occ <= 2'd1;
                    2'd1: begin
                        if (push && !pop)      occ <= 2'd2;
                        else if (!push && pop) occ <= 2'd0;
                    end
                    2'd2: if (pop) occ <= 2'd1;
                    default: occ <= occ;
                endcase
            end
        end
    end

    // Payload registers carry no reset; out_valid masks their contents.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            case (occ)
                2'd0: if (push) main_dat <= in_data;
                2'd1: begin
                    if (push && pop)  main_dat <= in_data;
                    else if (push)    skid_dat <= in_data;
                end
                2'd2: if (pop) main_dat <= skid_dat;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 SHALL provide parameter DATA_W, default 96, meaning payload width (64-bit PC plus 32-bit instruction).
REQ-002 SHALL provide parameter BUBBLE_VAL, default all-zero DATA_W vector, meaning the value driven on out_data while out_valid=0.
REQ-003 SHALL provide parameter CNT_W, default 16, meaning the width of the stall-cycle counter.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-006 SHALL have port flush, input, 1, which discards all held entries.
REQ-007 SHALL have port in_valid, input, 1, asserted when upstream presents a payload.
REQ-008 SHALL have port in_data, input, DATA_W, the upstream payload.
REQ-009 SHALL have port in_ready, output, 1, asserted when the stage can accept a payload.
REQ-010 SHALL have port out_valid, output, 1, asserted when a payload is held for downstream.
REQ-011 SHALL have port out_data, output, DATA_W, the oldest held payload, or BUBBLE_VAL.
REQ-012 SHALL have port out_ready, input, 1, asserted when downstream accepts.
REQ-013 SHALL have port occupancy, output, 2, the number of held entries (0..2).
REQ-014 SHALL have port stall_cnt, output, CNT_W, a saturating count of back-pressured cycles.

Function
REQ-015 SHALL hold at most two entries, main (head) and skid, in strict FIFO order.
REQ-016 SHALL define push = in_valid & in_ready and pop = out_valid & out_ready.
REQ-017 SHALL drive in_ready = (occupancy != 2), decoded from registered state only, with no combinational path from out_ready.
REQ-018 SHALL drive out_valid = (occupancy != 0) and out_data = main when valid, else BUBBLE_VAL.
REQ-019 SHALL have a latency of 1 cycle: a push into an empty stage is visible on out_valid/out_data the next cycle.
REQ-020 SHALL apply these occupancy transitions, with all other combinations holding state:
- 0 with push: payload goes to main, next occupancy 1.
- 1 with push and no pop: payload goes to skid, next occupancy 2.
- 1 with push and pop: main is replaced by the payload, occupancy stays 1.
- 1 with pop and no push: next occupancy 0.
- 2 with pop: skid moves to main, next occupancy 1 (no push is possible at occupancy 2).
REQ-021 SHALL leave entry contents unchanged when they are not written, including on an idle stall.
REQ-022 SHALL, on flush, set occupancy to 0 next cycle, drop any push in that cycle, and ignore pop that cycle; flush overrides all other events.
REQ-023 SHALL increment stall_cnt in each cycle where out_valid=1, out_ready=0 and flush=0.
REQ-024 SHALL saturate stall_cnt at 2^CNT_W-1, never wrapping.
REQ-025 SHALL not clear stall_cnt on flush.
REQ-026 SHALL tolerate in_data changing while in_valid=0; only pushed values are stored.

Reset
REQ-027 SHALL, while rst=1 at a rising edge, force occupancy=0 and stall_cnt=0, giving out_valid=0, out_data=BUBBLE_VAL and in_ready=1 the next cycle.
REQ-028 SHALL give rst priority over flush, push and pop; a payload pushed in the reset cycle is lost.
REQ-029 SHALL leave entry data registers un-reset, since they are masked by out_valid.

Verification
REQ-030 SHALL cover: reset, then push 0xA..01 with out_ready=1 -> out_valid=1 and out_data=0xA..01 one cycle later; occupancy returns to 0 after the pop.
REQ-031 SHALL cover: out_ready=0, push P1 then P2 -> occupancy=2 and in_ready=0; release out_ready -> P1 then P2 on consecutive cycles, with no loss or duplication.
REQ-032 SHALL cover: occupancy=1 with simultaneous push P3 and pop -> occupancy stays 1 and out_data=P3 next cycle.
REQ-033 SHALL cover: occupancy=2 with flush and in_valid=1 -> next cycle occupancy=0, out_data=BUBBLE_VAL, in_ready=1, and the pushed payload is absent.
REQ-034 SHALL cover: CNT_W=4 with out_valid=1 and out_ready=0 held for 20 cycles -> stall_cnt=15, held; a subsequent flush leaves it at 15, and rst clears it to 0.
REQ-035 SHALL cover: random valid/ready/flush streams for 10k cycles -> the output sequence matches a reference FIFO model, and in_ready never depends combinationally on out_ready.
